// File: rtl/latentred_ingress_pkg.sv
// rtl/latentred_ingress_pkg.sv - URAM word and frame descriptor types shared by ingress write and read sides
package latentred_ingress_pkg;

  localparam int NUM_PORTS_MAX    = 32;
  localparam int URAM_WORD_ADDR_W = 12;
  localparam int FRAME_LEN_W      = 11;
  localparam int PORT_W           = 5;

  typedef struct packed {
    logic [3:0]  rsvd;
    logic [3:0]  bytecount;
    logic [63:0] data;
  } uram_word_t;

  typedef struct packed {
    logic [URAM_WORD_ADDR_W-1:0] addr;
    logic [FRAME_LEN_W-1:0]      len;
  } ingress_desc_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_RETIRE
  } rd_state_e;

  // Byte count 1..8 to LSB-first keep mask.
  function automatic logic [7:0] bytecount_to_keep(input logic [3:0] cnt);
    logic [8:0] ones;
    ones = (9'd1 << cnt) - 9'd1;
    return ones[7:0];
  endfunction

endpackage

// File: rtl/ingress_rr_arbiter.sv
// rtl/ingress_rr_arbiter.sv - combinational round-robin grant: first request at or after the pointer
module ingress_rr_arbiter #(
  parameter int NUM_PORTS = 24
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [4:0]           ptr_i,
  output logic [NUM_PORTS-1:0] grant_o,
  output logic [4:0]           grant_idx_o,
  output logic                 grant_valid_o
);

  int         idx;
  logic [4:0] cand;

  always_comb begin
    grant_o       = '0;
    grant_idx_o   = '0;
    grant_valid_o = 1'b0;
    idx           = 0;
    cand          = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = int'(ptr_i) + i;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      cand = 5'(idx);
      if (!grant_valid_o && req_i[cand]) begin
        grant_valid_o = 1'b1;
        grant_idx_o   = cand;
        grant_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ingress_bank_reader.sv
// rtl/ingress_bank_reader.sv - drains queued frames from the cascaded URAM read chain to a 64-bit stream
// Defining INGRESS_READER_STATS_EN adds stat_frames/stat_stall saturating counters.
module ingress_bank_reader #(
  parameter int NUM_PORTS    = 24,
  parameter int READ_LATENCY = 8,
  parameter int SKID_DEPTH   = 16
) (
  input  logic                    clk_fabric,
  input  logic                    rst_fabric,
  input  logic [NUM_PORTS-1:0]    desc_valid,
  output logic [NUM_PORTS-1:0]    desc_ready,
  input  logic [NUM_PORTS*12-1:0] desc_addr,
  input  logic [NUM_PORTS*11-1:0] desc_len,
  output logic                    rd_en,
  output logic [16:0]             rd_addr,
  input  logic [71:0]             rd_data,
  input  logic                    rd_valid,
  output logic                    free_valid,
  output logic [4:0]              free_port,
  output logic [10:0]             free_words,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic [63:0]             m_tdata,
  output logic [7:0]              m_tkeep,
  output logic                    m_tlast,
  output logic [4:0]              m_tid
`ifdef INGRESS_READER_STATS_EN
  ,
  output logic [NUM_PORTS*32-1:0] stat_frames,
  output logic [31:0]             stat_stall
`endif
);

  import latentred_ingress_pkg::*;

  localparam int CRED_W = $clog2(SKID_DEPTH + 1);
  localparam int PTR_W  = $clog2(SKID_DEPTH);

  rd_state_e         state_q, state_d;
  logic [4:0]        rr_q, rr_d;
  logic [4:0]        port_q, port_d;
  ingress_desc_t     cur_q, cur_d;
  logic [10:0]       rem_q, rem_d;
  logic [CRED_W-1:0] credits_q, credits_d;
  logic              issue_last;

  logic [NUM_PORTS-1:0] grant;
  logic [4:0]           grant_idx;
  logic                 grant_valid;

  ingress_rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
    .req_i         (desc_valid),
    .ptr_i         (rr_q),
    .grant_o       (grant),
    .grant_idx_o   (grant_idx),
    .grant_valid_o (grant_valid)
  );

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    port_d     = port_q;
    cur_d      = cur_q;
    rem_d      = rem_q;
    desc_ready = '0;
    rd_en      = 1'b0;
    free_valid = 1'b0;
    issue_last = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant_valid && !rst_fabric) begin
          desc_ready = grant;
          port_d     = grant_idx;
          cur_d.addr = desc_addr[grant_idx*12 +: 12];
          cur_d.len  = desc_len[grant_idx*11 +: 11];
          rem_d      = desc_len[grant_idx*11 +: 11];
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // Credits are the only stall: each outstanding read owns a skid slot.
        if (credits_q != '0) begin
          rd_en      = 1'b1;
          cur_d.addr = cur_q.addr + 12'd1;
          rem_d      = rem_q - 11'd1;
          if (rem_q <= 11'd1) begin
            issue_last = 1'b1;
            state_d    = ST_RETIRE;
          end
        end
      end
      ST_RETIRE: begin
        free_valid = 1'b1;
        rr_d       = (port_q == 5'(NUM_PORTS - 1)) ? 5'd0 : port_q + 5'd1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rd_addr    = {port_q, cur_q.addr};
  assign free_port  = free_valid ? port_q : 5'd0;
  assign free_words = free_valid ? cur_q.len : 11'd0;

  logic pop, push;
  assign pop       = m_tvalid && m_tready;
  assign credits_d = credits_q + CRED_W'(pop) - CRED_W'(rd_en);

  always_ff @(posedge clk_fabric) begin
    if (rst_fabric) begin
      state_q   <= ST_IDLE;
      rr_q      <= '0;
      port_q    <= '0;
      cur_q     <= '0;
      rem_q     <= '0;
      credits_q <= CRED_W'(SKID_DEPTH);
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      port_q    <= port_d;
      cur_q     <= cur_d;
      rem_q     <= rem_d;
      credits_q <= credits_d;
    end
  end

  // Sideband travels with each read so returning words pick up {last, port}.
  logic [READ_LATENCY-1:0]      sb_v_q;
  logic [READ_LATENCY-1:0][5:0] sb_info_q;
  uram_word_t                   rd_word;
  logic [3:0]                   unused_rsvd;

  assign rd_word     = rd_data;
  assign unused_rsvd = rd_word.rsvd;
  assign push        = rd_valid && sb_v_q[READ_LATENCY-1];

  logic [77:0]       skid_mem_q [SKID_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CRED_W-1:0] count_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(SKID_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk_fabric) begin
    if (rst_fabric) begin
      sb_v_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      sb_v_q <= {sb_v_q[READ_LATENCY-2:0], rd_en};
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CRED_W'(push) - CRED_W'(pop);
    end
  end

  always_ff @(posedge clk_fabric) begin
    sb_info_q <= {sb_info_q[READ_LATENCY-2:0], {issue_last, port_q}};
    if (push) begin
      skid_mem_q[wr_ptr_q] <= {sb_info_q[READ_LATENCY-1],
                               bytecount_to_keep(rd_word.bytecount), rd_word.data};
    end
  end

  assign m_tvalid = (count_q != '0);
  assign {m_tlast, m_tid, m_tkeep, m_tdata} = m_tvalid ? skid_mem_q[rd_ptr_q] : 78'd0;

`ifdef INGRESS_READER_STATS_EN
  logic [31:0] frames_q [NUM_PORTS];
  logic [31:0] stall_q;

  always_ff @(posedge clk_fabric) begin
    if (rst_fabric) begin
      for (int p = 0; p < NUM_PORTS; p++) frames_q[p] <= '0;
      stall_q <= '0;
    end else begin
      if (pop && m_tlast && frames_q[m_tid] != '1) frames_q[m_tid] <= frames_q[m_tid] + 32'd1;
      if (state_q == ST_ISSUE && credits_q == '0 && stall_q != '1) stall_q <= stall_q + 32'd1;
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_stat
    assign stat_frames[g*32 +: 32] = frames_q[g];
  end
  assign stat_stall = stall_q;
`else
  // Statistics counters not built.
`endif

endmodule

// File: tb/tb_ingress_bank_reader.sv
// tb/tb_ingress_bank_reader.sv - directed self-checking bench for ingress_bank_reader
module tb_ingress_bank_reader;

  localparam int NP = 24;
  localparam int RL = 8;
  localparam int SD = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [NP-1:0]     desc_valid;
  logic [NP-1:0]     desc_ready;
  logic [NP*12-1:0]  desc_addr;
  logic [NP*11-1:0]  desc_len;
  logic              rd_en;
  logic [16:0]       rd_addr;
  logic [71:0]       rd_data;
  logic              rd_valid;
  logic              free_valid;
  logic [4:0]        free_port;
  logic [10:0]       free_words;
  logic              m_tvalid;
  logic              m_tready;
  logic [63:0]       m_tdata;
  logic [7:0]        m_tkeep;
  logic              m_tlast;
  logic [4:0]        m_tid;

  ingress_bank_reader #(.NUM_PORTS(NP), .READ_LATENCY(RL), .SKID_DEPTH(SD)) dut (
    .clk_fabric (clk),
    .rst_fabric (rst),
    .desc_valid (desc_valid),
    .desc_ready (desc_ready),
    .desc_addr  (desc_addr),
    .desc_len   (desc_len),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .free_valid (free_valid),
    .free_port  (free_port),
    .free_words (free_words),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tdata    (m_tdata),
    .m_tkeep    (m_tkeep),
    .m_tlast    (m_tlast),
    .m_tid      (m_tid)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] exp_data(input logic [16:0] a);
    return {15'h1ACE, a, 15'h2B0D, a};
  endfunction

  function automatic logic [71:0] mk_word(input logic [16:0] a);
    logic [3:0] bc;
    bc = 4'd8;
    if (a == 17'h03013) bc = 4'd5;
    if (a == 17'h07001) bc = 4'd3;
    return {4'hA, bc, exp_data(a)};
  endfunction

  // URAM cascade model: fixed RL-cycle read latency.
  logic [RL-1:0] pv = '0;
  logic [16:0]   pa [RL];
  always @(posedge clk) begin
    pv    <= {pv[RL-2:0], rd_en};
    pa[0] <= rd_addr;
    for (int k = 1; k < RL; k++) pa[k] <= pa[k-1];
  end
  assign rd_valid = pv[RL-1];
  assign rd_data  = mk_word(pa[RL-1]);

  int          q_rd_cyc[$];
  logic [16:0] q_rd_addr[$];
  logic [63:0] q_bd[$];
  logic [7:0]  q_bk[$];
  logic        q_bl[$];
  logic [4:0]  q_bt[$];
  logic [4:0]  q_fp[$];
  logic [10:0] q_fw[$];
  int          q_f_cyc[$];
  int          q_grant[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (rd_en) begin
        q_rd_addr.push_back(rd_addr);
        q_rd_cyc.push_back(cyc);
      end
      if (m_tvalid && m_tready) begin
        q_bd.push_back(m_tdata);
        q_bk.push_back(m_tkeep);
        q_bl.push_back(m_tlast);
        q_bt.push_back(m_tid);
      end
      if (free_valid) begin
        q_fp.push_back(free_port);
        q_fw.push_back(free_words);
        q_f_cyc.push_back(cyc);
      end
      for (int p = 0; p < NP; p++) if (desc_ready[p]) q_grant.push_back(p);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    q_rd_cyc.delete(); q_rd_addr.delete();
    q_bd.delete(); q_bk.delete(); q_bl.delete(); q_bt.delete();
    q_fp.delete(); q_fw.delete(); q_f_cyc.delete(); q_grant.delete();
  endtask

  task automatic set_desc(input int p, input logic [11:0] a, input logic [10:0] l);
    desc_addr[p*12 +: 12] = a;
    desc_len[p*11 +: 11]  = l;
    desc_valid[p]         = 1'b1;
  endtask

  logic rearm0 = 1'b0;

  // One cycle; withdraws any descriptor the DUT accepted.
  task automatic step();
    logic [NP-1:0] rdy;
    @(negedge clk);
    rdy = desc_ready;
    @(posedge clk); #1;
    desc_valid = desc_valid & ~rdy;
    if (rearm0 && rdy[5]) begin
      rearm0 = 1'b0;
      set_desc(0, 12'h0C0, 11'd1);
    end
  endtask

  task automatic wait_done(input string tag, input int nb, input int nf, input int budget);
    int i;
    i = 0;
    while ((q_bd.size() < nb || q_fp.size() < nf) && i < budget) begin
      step();
      i++;
    end
    chk(tag, (q_bd.size() >= nb && q_fp.size() >= nf), 1'b1);
    repeat (4) step();
  endtask

  int errs;
  int nl;

  initial begin
    rst        = 1'b1;
    desc_valid = '0;
    desc_addr  = '0;
    desc_len   = '0;
    m_tready   = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_desc_ready", desc_ready, 0);
    chk("rst_free_valid", free_valid, 0);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_m_tdata", m_tdata, 0);
    chk("rst_m_tkeep_tlast_tid", {m_tkeep, m_tlast, m_tid}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    clear_logs();

    // Port 3, 4 words, last bytecount 5
    set_desc(3, 12'h010, 11'd4);
    wait_done("p3_done", 4, 1, 100);
    chk("p3_grant", q_grant[0], 3);
    chk("p3_rd_count", q_rd_addr.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("p3_rd_addr%0d", i), q_rd_addr[i], 17'h03010 + 17'(i));
    chk("p3_beats", q_bd.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("p3_data%0d", i), q_bd[i], exp_data(17'h03010 + 17'(i)));
    chk("p3_keep", {q_bk[0], q_bk[1], q_bk[2], q_bk[3]}, 32'hFFFFFF1F);
    chk("p3_last", {q_bl[0], q_bl[1], q_bl[2], q_bl[3]}, 4'b0001);
    chk("p3_tid", {q_bt[0], q_bt[1], q_bt[2], q_bt[3]}, {5'd3, 5'd3, 5'd3, 5'd3});
    chk("p3_free", {q_fp[0], q_fw[0]}, {5'd3, 11'd4});

    // Round robin from pointer 0, port 0 re-requests after port 5 is granted
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    clear_logs();
    set_desc(0, 12'h000, 11'd2);
    set_desc(5, 12'h040, 11'd2);
    set_desc(23, 12'h080, 11'd2);
    rearm0 = 1'b1;
    wait_done("rr_done", 7, 4, 300);
    chk("rr_grants", {q_grant[0][4:0], q_grant[1][4:0], q_grant[2][4:0], q_grant[3][4:0]},
        {5'd0, 5'd5, 5'd23, 5'd0});
    chk("rr_free_ports", {q_fp[0], q_fp[1], q_fp[2], q_fp[3]}, {5'd0, 5'd5, 5'd23, 5'd0});
    chk("rr_free_words", {q_fw[0], q_fw[1], q_fw[2], q_fw[3]}, {11'd2, 11'd2, 11'd2, 11'd1});
    chk("rr_tids", {q_bt[0], q_bt[1], q_bt[2], q_bt[3], q_bt[4], q_bt[5], q_bt[6]},
        {5'd0, 5'd0, 5'd5, 5'd5, 5'd23, 5'd23, 5'd0});
    chk("rr_last_rd_addr", q_rd_addr[6], 17'h000C0);

    // Address wrap inside the port block
    clear_logs();
    set_desc(7, 12'hFFE, 11'd4);
    wait_done("wrap_done", 4, 1, 100);
    chk("wrap_rd_addr", {q_rd_addr[0], q_rd_addr[1], q_rd_addr[2], q_rd_addr[3]},
        {17'h07FFE, 17'h07FFF, 17'h07000, 17'h07001});
    chk("wrap_last_keep", {q_bl[3], q_bk[3]}, {1'b1, 8'h07});
    chk("wrap_data3", q_bd[3], exp_data(17'h07001));

    // Output stalled: issue stops at SKID_DEPTH, then the frame drains intact
    clear_logs();
    m_tready = 1'b0;
    set_desc(2, 12'h100, 11'd40);
    repeat (100) step();
    chk("stall_issue_count", q_rd_addr.size(), SD);
    chk("stall_last_issued", q_rd_addr[SD-1], 17'h0210F);
    chk("stall_no_beats", q_bd.size(), 0);
    @(negedge clk);
    chk("stall_head_valid", m_tvalid, 1);
    chk("stall_head_data", m_tdata, exp_data(17'h02100));
    @(posedge clk); #1;
    m_tready = 1'b1;
    wait_done("stall_done", 40, 1, 400);
    chk("stall_beats", q_bd.size(), 40);
    chk("stall_rd_total", q_rd_addr.size(), 40);
    errs = 0;
    nl   = 0;
    for (int i = 0; i < 40; i++) begin
      if (q_bd[i] !== exp_data(17'h02100 + 17'(i))) errs++;
      if (q_bl[i]) nl++;
    end
    chk("stall_data_order", errs, 0);
    chk("stall_tlast_count", nl, 1);
    chk("stall_tlast_pos", q_bl[39], 1);

    // Single-word frame followed by a queued frame
    clear_logs();
    set_desc(9, 12'h020, 11'd1);
    set_desc(10, 12'h030, 11'd2);
    wait_done("len1_done", 3, 2, 200);
    chk("len1_beat", {q_bl[0], q_bt[0], q_bk[0]}, {1'b1, 5'd9, 8'hFF});
    chk("len1_free", {q_fp[0], q_fw[0]}, {5'd9, 11'd1});
    chk("len1_next_addr", q_rd_addr[1], 17'h0A030);
    chk("len1_gap", q_rd_cyc[1] - q_f_cyc[0], 2);

    // Reset in the middle of ISSUE
    clear_logs();
    set_desc(4, 12'h200, 11'd40);
    repeat (6) step();
    rst        = 1'b1;
    desc_valid = '0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_rd_en", rd_en, 0);
    chk("midrst_m_tvalid", m_tvalid, 0);
    chk("midrst_free_valid", free_valid, 0);
    chk("midrst_desc_ready", desc_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    clear_logs();
    repeat (20) step();
    chk("midrst_late_dropped", q_bd.size(), 0);
    chk("midrst_no_free", q_fp.size(), 0);
    m_tready = 1'b0;
    set_desc(6, 12'h300, 11'd20);
    repeat (60) step();
    chk("midrst_credits", q_rd_addr.size(), SD);
    m_tready = 1'b1;
    wait_done("midrst_done", 20, 1, 300);
    chk("midrst_beats", q_bd.size(), 20);
    errs = 0;
    for (int i = 0; i < 20; i++) if (q_bd[i] !== exp_data(17'h06300 + 17'(i))) errs++;
    chk("midrst_data_order", errs, 0);
    chk("midrst_free", {q_fp[0], q_fw[0]}, {5'd6, 11'd20});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
